btn_conditioner: RTL and testbench
==================================

BTN_CONDITIONER -- requirements
Module: btn_conditioner

Interface
REQ-001 SHALL have parameter NUM_BTN, default 8: number of button channels.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth, legal range 2..3.
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 50000 (1 ms at 50 MHz): cycles of stable disagreement required to accept a change, minimum 2.
REQ-004 SHALL have port clk  input  1  single system clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port btn_raw  input  NUM_BTN  asynchronous, bouncy, active-high button pins.
REQ-007 SHALL have port en  input  1  press-reporting enable; low while the game is idle or ended.
REQ-008 SHALL have port btn_level  output  NUM_BTN  debounced level per channel.
REQ-009 SHALL have port btn_press  output  NUM_BTN  one-cycle pulse per channel on each debounced rising edge; this is the btn bus the game consumes.
REQ-010 SHALL have port press_valid  output  1  one-cycle pulse when at least one btn_press bit is set.
REQ-011 SHALL have port press_idx  output  clog2(NUM_BTN)  index of the lowest-numbered pressed channel; valid only with press_valid.
REQ-012 SHALL have port multi_press  output  1  one-cycle pulse when more than one btn_press bit is set in the same cycle.

Function
REQ-013 Each channel SHALL pass btn_raw through SYNC_STAGES flip-flops before any other logic uses it.
REQ-014 Each channel SHALL hold a stable bit and a counter of width clog2(DEBOUNCE_CYCLES).
REQ-015 On an edge where the synchronized value equals stable, the counter SHALL clear to 0.
REQ-016 On an edge where they differ and counter < DEBOUNCE_CYCLES-1, the counter SHALL increment.
REQ-017 On an edge where they differ and counter == DEBOUNCE_CYCLES-1, stable SHALL take the synchronized value and the counter SHALL clear.
REQ-018 A raw change first sampled at edge k and then held SHALL appear on btn_level after edge k+SYNC_STAGES+DEBOUNCE_CYCLES-1.
REQ-019 A raw pulse or glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL not change btn_level; the counter restarts from 0 on every bounce.
REQ-020 btn_press[i] SHALL be a registered pulse, high for exactly the one cycle in which btn_level[i] first reads 1 after a 0->1 update, gated by en.
REQ-021 Debounced falling edges SHALL produce no pulse.
REQ-022 When en is low, btn_press, press_valid and multi_press SHALL be 0; debouncing and btn_level SHALL continue unaffected.
REQ-023 A rise that occurs while en is low SHALL not be reported later when en goes high.
REQ-024 press_valid, press_idx and multi_press SHALL be registered in the same cycle as btn_press; press_idx gives lowest index priority.
REQ-025 Channels SHALL be fully independent; simultaneous rises on several channels SHALL pulse all of the corresponding btn_press bits in the same cycle.
REQ-026 When press_valid is 0, press_idx SHALL be 0.

Reset
REQ-027 On rst_n low, all synchronizer flops, stable bits and counters SHALL clear asynchronously, and btn_level, btn_press, press_valid, press_idx and multi_press SHALL be 0.
REQ-028 A button held through reset release SHALL be treated as a new rise: btn_level rises after the REQ-018 latency, with one btn_press pulse if en is high.
REQ-029 Reset asserted mid-debounce SHALL discard the partial count.

Structure
REQ-030 A shared package SHALL hold the NUM_BTN and DEBOUNCE_CYCLES defaults and the clock-frequency constant; the whack_a_mole top and this block SHALL both import it.
REQ-031 The per-channel synchronizer plus debouncer SHALL be one sub-module, btn_debounce_ch, instantiated NUM_BTN times; edge detection and priority encoding SHALL live in btn_conditioner.

Verification (bench uses DEBOUNCE_CYCLES=4, SYNC_STAGES=2, en=1 unless stated)
REQ-032 Raw btn_raw[3] rises and is held -> btn_level[3] rises 5 edges later; btn_press=8'h08, press_valid=1, press_idx=3 for exactly 1 cycle.
REQ-033 btn_raw[0] toggles every 2 cycles for 20 cycles, then is held low -> btn_level and btn_press stay 0 throughout.
REQ-034 btn_raw[2] and btn_raw[5] rise on the same edge -> btn_press=8'h24, press_idx=2, multi_press=1 for 1 cycle.
REQ-035 en=0 while btn_raw[7] rises and settles, then en=1 -> btn_level[7]=1 and no btn_press pulse at any time; release and re-press with en=1 -> one pulse.
REQ-036 rst_n pulsed low 2 cycles into debouncing btn_raw[1] -> all outputs 0 immediately; with the button still held, btn_level[1] rises 5 edges after the first edge following reset release, with one pulse.

Source files
------------

// File: rtl/btn_conditioner_pkg.sv
// Shared constants for the button front end and the game top that consumes it.
package btn_conditioner_pkg;

  // System clock frequency in Hz.
  localparam int unsigned CLK_FREQ_HZ         = 50_000_000;

  // Default number of button channels.
  localparam int unsigned DEF_NUM_BTN         = 8;

  // Default synchronizer depth.
  localparam int unsigned DEF_SYNC_STAGES     = 2;

  // Default debounce window: 1 ms at CLK_FREQ_HZ.
  localparam int unsigned DEF_DEBOUNCE_MS     = 1;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = (CLK_FREQ_HZ / 1000) * DEF_DEBOUNCE_MS;

  // Width of an index into n channels. A single channel still gets one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: multi-flop synchronizer followed by a counter debouncer.
// o_level is the accepted (stable) value. o_level_nxt is the value it takes at
// the next edge, so the parent can register an edge pulse aligned with o_level.
module btn_debounce_ch
  import btn_conditioner_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_level,
  output logic o_level_nxt
);

  localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync_p0;
  logic                   w_sync;
  logic                   r_stable;
  logic                   w_stable_nxt;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_cnt_nxt;

  // Synchronizer chain: the raw pin is only ever seen through the last flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync_p0 <= '0;
    end else begin
      r_sync_p0 <= {r_sync_p0[SYNC_STAGES-2:0], i_raw};
    end
  end

  assign w_sync = r_sync_p0[SYNC_STAGES-1];

  // Debounce decision: any agreement restarts the window, a full window of
  // disagreement accepts the synchronized value.
  always_comb begin
    w_stable_nxt = r_stable;
    w_cnt_nxt    = '0;
    if (w_sync != r_stable) begin
      if (r_cnt == CNT_MAX) begin
        w_stable_nxt = w_sync;
      end else begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
      end
    end
  end

  // Debounce state; reset discards any partial count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_stable <= w_stable_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end

  assign o_level     = r_stable;
  assign o_level_nxt = w_stable_nxt;

endmodule

// File: rtl/btn_conditioner.sv
// Button front end: per-channel synchronize/debounce, then registered rising-
// edge pulses gated by en, with a lowest-index priority encoder and a
// multiple-press flag, all aligned to the cycle the level first reads 1.
module btn_conditioner
  import btn_conditioner_pkg::*;
#(
  parameter int NUM_BTN         = DEF_NUM_BTN,
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_BTN-1:0]               btn_raw,
  input  logic                             en,
  output logic [NUM_BTN-1:0]               btn_level,
  output logic [NUM_BTN-1:0]               btn_press,
  output logic                             press_valid,
  output logic [idx_width(NUM_BTN)-1:0]    press_idx,
  output logic                             multi_press
);

  localparam int IDX_W = idx_width(NUM_BTN);

  logic [NUM_BTN-1:0] w_level;
  logic [NUM_BTN-1:0] w_level_nxt;
  logic [NUM_BTN-1:0] w_rise;
  logic               w_any;
  logic               w_multi;
  logic [IDX_W-1:0]   w_idx;

  logic [NUM_BTN-1:0] r_press_p1;
  logic               r_valid_p1;
  logic [IDX_W-1:0]   r_idx_p1;
  logic               r_multi_p1;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
    btn_debounce_ch #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_raw       (btn_raw[g]),
      .o_level     (w_level[g]),
      .o_level_nxt (w_level_nxt[g])
    );
  end

  // A rise is a 0->1 update about to be accepted; rises while disabled are
  // simply dropped, so nothing is replayed when en returns.
  assign w_rise = w_level_nxt & ~w_level & {NUM_BTN{en}};

  // Priority encode (lowest index wins) and detect more than one set bit.
  always_comb begin
    w_idx   = '0;
    w_any   = |w_rise;
    w_multi = (w_rise & (w_rise - NUM_BTN'(1))) != '0;
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (w_rise[i]) begin
        w_idx = IDX_W'(i);
      end
    end
  end

  // ---- stage p1: press outputs, registered alongside the level update ----
  // Register the press bus and its summary so all land in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_press_p1 <= '0;
      r_valid_p1 <= 1'b0;
      r_idx_p1   <= '0;
      r_multi_p1 <= 1'b0;
    end else begin
      r_press_p1 <= w_rise;
      r_valid_p1 <= w_any;
      r_idx_p1   <= w_idx;
      r_multi_p1 <= w_multi;
    end
  end

  assign btn_level   = w_level;
  assign btn_press   = r_press_p1;
  assign press_valid = r_valid_p1;
  assign press_idx   = r_idx_p1;
  assign multi_press = r_multi_p1;

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
// Inputs change 1 ns after a rising edge; outputs are observed at that same
// point, i.e. they reflect the edge just taken.
module tb_btn_conditioner;

  localparam int NUM_BTN = 8;
  localparam int IDX_W   = 3;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NUM_BTN-1:0] btn_raw;
  logic               en;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_press;
  logic               press_valid;
  logic [IDX_W-1:0]   press_idx;
  logic               multi_press;

  int n_assert = 0;
  int n_fail   = 0;

  btn_conditioner #(
    .NUM_BTN         (NUM_BTN),
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_raw     (btn_raw),
    .en          (en),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .press_valid (press_valid),
    .press_idx   (press_idx),
    .multi_press (multi_press)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s @%0t: observed %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] lvl, input logic [7:0] prs,
                         input logic vld, input logic [2:0] idx, input logic mul);
    chk({tag, ".level"}, 32'(btn_level),   32'(lvl));
    chk({tag, ".press"}, 32'(btn_press),   32'(prs));
    chk({tag, ".valid"}, 32'(press_valid), 32'(vld));
    chk({tag, ".idx"},   32'(press_idx),   32'(idx));
    chk({tag, ".multi"}, 32'(multi_press), 32'(mul));
  endtask

  initial begin
    rst_n   = 1'b0;
    btn_raw = '0;
    en      = 1'b1;
    tick();
    tick();
    chk_all("reset", 8'h00, 8'h00, 1'b0, 3'd0, 1'b0);
    rst_n = 1'b1;
    tick();
    tick();
    chk_all("idle", 8'h00, 8'h00, 1'b0, 3'd0, 1'b0);

    // Single press on channel 3: level and press land after the 6th edge.
    btn_raw = 8'h08;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk_all("b3_wait", 8'h00, 8'h00, 1'b0, 3'd0, 1'b0);
    end
    tick();
    chk_all("b3_press", 8'h08, 8'h08, 1'b1, 3'd3, 1'b0);
    tick();
    chk_all("b3_after", 8'h08, 8'h00, 1'b0, 3'd0, 1'b0);
    // Release: level falls after the same latency, no pulse.
    btn_raw = 8'h00;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk_all("b3_rel", (i < 6) ? 8'h08 : 8'h00, 8'h00, 1'b0, 3'd0, 1'b0);
    end

    // Bouncing channel 0: 2 high, 2 low, never long enough to be accepted.
    for (int c = 0; c < 20; c++) begin
      btn_raw = ((c / 2) % 2 == 0) ? 8'h01 : 8'h00;
      tick();
      chk_all("bounce", 8'h00, 8'h00, 1'b0, 3'd0, 1'b0);
    end
    btn_raw = 8'h00;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk_all("bounce_low", 8'h00, 8'h00, 1'b0, 3'd0, 1'b0);
    end

    // Simultaneous rises on channels 2 and 5.
    btn_raw = 8'h24;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk_all("dual_wait", 8'h00, 8'h00, 1'b0, 3'd0, 1'b0);
    end
    tick();
    chk_all("dual_press", 8'h24, 8'h24, 1'b1, 3'd2, 1'b1);
    tick();
    chk_all("dual_after", 8'h24, 8'h00, 1'b0, 3'd0, 1'b0);
    btn_raw = 8'h00;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk_all("dual_rel", (i < 6) ? 8'h24 : 8'h00, 8'h00, 1'b0, 3'd0, 1'b0);
    end

    // Channel 7 rises while disabled: level follows, no press now or later.
    en      = 1'b0;
    btn_raw = 8'h80;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk_all("dis_rise", (i >= 6) ? 8'h80 : 8'h00, 8'h00, 1'b0, 3'd0, 1'b0);
    end
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all("dis_reen", 8'h80, 8'h00, 1'b0, 3'd0, 1'b0);
    end
    btn_raw = 8'h00;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk_all("dis_rel", (i < 6) ? 8'h80 : 8'h00, 8'h00, 1'b0, 3'd0, 1'b0);
    end
    btn_raw = 8'h80;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk_all("b7_wait", 8'h00, 8'h00, 1'b0, 3'd0, 1'b0);
    end
    tick();
    chk_all("b7_press", 8'h80, 8'h80, 1'b1, 3'd7, 1'b0);
    tick();
    chk_all("b7_after", 8'h80, 8'h00, 1'b0, 3'd0, 1'b0);
    btn_raw = 8'h00;
    for (int i = 0; i < 6; i++) tick();
    chk_all("b7_rel", 8'h00, 8'h00, 1'b0, 3'd0, 1'b0);

    // Get channel 6 to a stable high so reset has something to clear.
    btn_raw = 8'h40;
    for (int i = 0; i < 5; i++) tick();
    tick();
    chk_all("b6_press", 8'h40, 8'h40, 1'b1, 3'd6, 1'b0);
    tick();
    // Start debouncing channel 1, then reset mid-count and drop channel 6.
    btn_raw = 8'h42;
    tick();
    tick();
    tick();
    chk_all("b1_mid", 8'h40, 8'h00, 1'b0, 3'd0, 1'b0);
    rst_n   = 1'b0;
    btn_raw = 8'h02;
    #1;
    chk_all("rst_async", 8'h00, 8'h00, 1'b0, 3'd0, 1'b0);
    tick();
    tick();
    chk_all("rst_hold", 8'h00, 8'h00, 1'b0, 3'd0, 1'b0);
    rst_n = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk_all("b1_wait", 8'h00, 8'h00, 1'b0, 3'd0, 1'b0);
    end
    tick();
    chk_all("b1_press", 8'h02, 8'h02, 1'b1, 3'd1, 1'b0);
    tick();
    chk_all("b1_after", 8'h02, 8'h00, 1'b0, 3'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
